// File: rtl/aes_dec_pkg.sv
// Shared types and GF(2^8) helpers for the AES-128 decryption round datapath.
package aes_dec_pkg;

  localparam int unsigned STATE_W = 128;
  localparam int unsigned NB      = 4;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned COL_W   = NB * BYTE_W;

  typedef logic [STATE_W-1:0] state_t;
  typedef logic [COL_W-1:0]   col_t;
  typedef logic [BYTE_W-1:0]  byte_t;

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
  function automatic byte_t xtime(input byte_t b);
    return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gmul9(input byte_t b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic byte_t gmul11(input byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic byte_t gmul13(input byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic byte_t gmul14(input byte_t b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Byte 0 sits at the MSBs; bytes are column-major (index = col*NB + row).
  function automatic int unsigned byte_lsb(input int unsigned row, input int unsigned col);
    return STATE_W - BYTE_W * (col * NB + row + 1);
  endfunction

endpackage

// File: rtl/aes_inv_mix_column.sv
// InvMixColumns on a single 32-bit column; row 0 occupies the top byte.
module aes_inv_mix_column
  import aes_dec_pkg::*;
(
  input  col_t col,
  output col_t mixed_c
);

  byte_t a0, a1, a2, a3;

  assign a0 = col[31:24];
  assign a1 = col[23:16];
  assign a2 = col[15:8];
  assign a3 = col[7:0];

  // Circulant matrix {14, 11, 13, 9}, rotated one step per output row.
  assign mixed_c = {gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
                    gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
                    gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3),
                    gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3)};

endmodule

// File: rtl/aes_inv_addkey_mix_stage.sv
// AddRoundKey then InvMixColumns (skippable on the last round) in a two-stage
// valid/ready pipeline with full backpressure.
module aes_inv_addkey_mix_stage #(
  parameter int unsigned STATE_W          = 128,
  parameter bit          SKIP_MIX_ON_LAST = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  input  logic [STATE_W-1:0] in_key,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state
);

  import aes_dec_pkg::*;

  if (STATE_W != aes_dec_pkg::STATE_W) begin : g_bad_width
    $error("aes_inv_addkey_mix_stage supports only a 128-bit state");
  end

  logic   s1_valid;
  logic   s1_last;
  state_t s1_data;
  logic   s2_valid;
  state_t s2_data;
  state_t mixed;
  logic   s2_free;
  logic   s1_adv;
  logic   load;

  // Handshake: in_ready depends only on pipeline occupancy and out_ready.
  always_comb begin
    s2_free  = !s2_valid || out_ready;
    s1_adv   = s1_valid && s2_free;
    in_ready = !s1_valid || s1_adv;
    load     = in_valid && in_ready;
  end

  for (genvar c = 0; c < NB; c++) begin : g_col
    aes_inv_mix_column u_mix (
      .col     (s1_data[byte_lsb(NB-1, c) +: COL_W]),
      .mixed_c (mixed[byte_lsb(NB-1, c) +: COL_W])
    );
  end

  // Stage 1: AddRoundKey.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_data  <= '0;
    end else begin
      if (load) begin
        s1_valid <= 1'b1;
        s1_last  <= in_last;
        s1_data  <= in_state ^ in_key;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: InvMixColumns or last-round bypass.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else begin
      if (s1_adv) begin
        s2_valid <= 1'b1;
        s2_data  <= (SKIP_MIX_ON_LAST && s1_last) ? s1_data : mixed;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_state = s2_data;

endmodule

// File: tb/tb_aes_inv_addkey_mix_stage.sv
// Randomized and directed bench for aes_inv_addkey_mix_stage with a byte-level reference model.
module tb_aes_inv_addkey_mix_stage;

  localparam bit SKIP = 1'b1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_state = '0;
  logic [127:0] in_key = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_state;

  int n_checks = 0;
  int n_errors = 0;
  int n_out = 0;
  logic [127:0] exp_q[$];

  aes_inv_addkey_mix_stage #(.STATE_W(128), .SKIP_MIX_ON_LAST(SKIP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_key    (in_key),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] aa;
    logic [7:0] bb;
    logic [7:0] p;
    aa = {1'b0, a};
    bb = b;
    p  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa[7:0];
      aa = aa << 1;
      if (aa[8]) aa = aa ^ 9'h11b;
      bb = bb >> 1;
    end
    return p;
  endfunction

  // AddRoundKey on bytes, then InvMixColumns as a 4x4 matrix product per column.
  function automatic logic [127:0] ref_block(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [7:0] b[16];
    logic [7:0] o[16];
    logic [7:0] m0[4];
    logic [127:0] r;
    m0[0] = 8'd14; m0[1] = 8'd11; m0[2] = 8'd13; m0[3] = 8'd9;
    for (int i = 0; i < 16; i++) b[i] = s[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) begin
        o[4*c+rr] = 8'h00;
        for (int j = 0; j < 4; j++) o[4*c+rr] = o[4*c+rr] ^ gf_mul(m0[(j - rr + 4) % 4], b[4*c+j]);
      end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = (SKIP && last) ? b[i] : o[i];
    return r;
  endfunction

  // Scoreboard: handshakes sampled mid-cycle, effective at the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) check("sb_extra_output", 128'(out_valid), 128'(0));
        else check("sb_data", out_state, exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(ref_block(in_state, in_key, in_last));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_ready(input string tag);
    int budget = 50;
    while (!in_ready && budget > 0) begin
      step();
      budget--;
    end
    if (!in_ready) check(tag, 128'(in_ready), 128'(1));
  endtask

  // Single block, no stall: S1 after the accepting edge, output after the next.
  task automatic send_dir(input string tag, input logic [127:0] s, input logic [127:0] k,
                          input logic last, input logic [127:0] expv);
    out_ready = 1'b1;
    in_valid = 1'b1; in_state = s; in_key = k; in_last = last;
    #1;
    wait_ready({tag, "_ready_tmo"});
    step();
    in_valid = 1'b0;
    check({tag, "_lat_early"}, 128'(out_valid), 128'(0));
    step();
    check({tag, "_lat_valid"}, 128'(out_valid), 128'(1));
    check({tag, "_data"}, out_state, expv);
    step();
  endtask

  initial begin
    logic [127:0] snap;
    logic [127:0] blk[4];
    logic acc;
    int start_out;
    int budget;

    // Reset with in_valid held high.
    rst = 1'b1; in_valid = 1'b1; in_state = rnd128(); in_key = rnd128();
    step();
    check("rst_out_valid0", 128'(out_valid), 128'(0));
    step();
    check("rst_out_valid1", 128'(out_valid), 128'(0));
    check("rst_out_state", out_state, 128'(0));
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_in_ready", 128'(in_ready), 128'(1));
    step();
    check("idle_out_valid", 128'(out_valid), 128'(0));

    // Known InvMixColumns vectors and last-round bypass.
    send_dir("imc_vec", {4{32'h8e4da1bc}}, 128'(0), 1'b0, {4{32'hdb135345}});
    send_dir("imc_c6", {4{32'hc6c6c6c6}}, 128'(0), 1'b0, {4{32'hc6c6c6c6}});
    send_dir("last_bypass", {16{8'hff}}, {16{8'h0f}}, 1'b1, {16{8'hf0}});
    send_dir("last0_mix", {16{8'hff}}, {16{8'h0f}}, 1'b0, {16{8'hf0}});
    send_dir("rand_mix", 128'h0123456789abcdeffedcba9876543210, 128'h00112233445566778899aabbccddeeff, 1'b0,
             ref_block(128'h0123456789abcdeffedcba9876543210, 128'h00112233445566778899aabbccddeeff, 1'b0));

    // Back-to-back: 8 blocks, outputs on consecutive cycles.
    out_ready = 1'b1;
    start_out = n_out;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i < 8);
      in_state = rnd128(); in_key = rnd128(); in_last = 1'(($urandom) & 1);
      #1;
      if (i < 8) check("tput_in_ready", 128'(in_ready), 128'(1));
      step();
      check("tput_out_valid", 128'(out_valid), 128'((i >= 1) && (i <= 8)));
    end
    in_valid = 1'b0;
    check("tput_count", 128'(n_out - start_out), 128'(8));

    // Backpressure: two accepts fill the pipe, output held stable.
    for (int i = 0; i < 4; i++) blk[i] = rnd128();
    start_out = n_out;
    out_ready = 1'b0; in_valid = 1'b1; in_key = 128'(0); in_last = 1'b0;
    in_state = blk[0];
    step();
    in_state = blk[1];
    step();
    in_state = blk[2];
    #1;
    check("bp_in_ready_low", 128'(in_ready), 128'(0));
    check("bp_out_valid", 128'(out_valid), 128'(1));
    snap = out_state;
    check("bp_head", snap, ref_block(blk[0], 128'(0), 1'b0));
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_stable", out_state, snap);
      check("bp_in_ready_held", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    #1;
    wait_ready("bp_ready_tmo");
    step();
    in_state = blk[3];
    #1;
    wait_ready("bp_ready_tmo2");
    step();
    in_valid = 1'b0;
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    check("bp_count", 128'(n_out - start_out), 128'(4));

    // Reset mid-flight: both in-flight blocks must vanish.
    out_ready = 1'b0; in_valid = 1'b1;
    in_state = rnd128(); in_key = rnd128();
    step();
    in_state = rnd128();
    step();
    start_out = n_out;
    rst = 1'b1; in_state = rnd128();
    step();
    check("mid_rst_out_valid", 128'(out_valid), 128'(0));
    check("mid_rst_out_state", out_state, 128'(0));
    check("mid_rst_in_ready", 128'(in_ready), 128'(1));
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("mid_rst_no_emit", 128'(out_valid), 128'(0));
    snap = rnd128();
    send_dir("post_rst", snap, 128'(0), 1'b0, ref_block(snap, 128'(0), 1'b0));
    check("mid_rst_count", 128'(n_out - start_out), 128'(1));

    // Randomized valid/ready traffic against the scoreboard.
    acc = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (acc) begin
        in_state = rnd128(); in_key = rnd128(); in_last = 1'(($urandom) & 1);
      end
      #1;
      acc = in_valid && in_ready;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    check("rand_drain", 128'(exp_q.size()), 128'(0));
    step();
    check("rand_idle", 128'(out_valid), 128'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
